// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
// Module  : debounce_sync
// Brief   : Synchronizes and debounces a raw asynchronous input into a clean
//           level, with registered single-cycle rise/fall pulses.
// Revision: 1.0 - initial release
// ============================================================================
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_async,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_dout;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_s;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_qualify;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A match at any point abandons the pending change, which is what rejects glitches.
    always_comb begin
        w_cnt_nxt = '0;
        w_qualify = 1'b0;
        if (w_s != r_dout) begin
            if (r_cnt == c_CNT_MAX) begin
                w_qualify = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_dout <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din_async};
            r_cnt  <= w_cnt_nxt;
            if (w_qualify) begin
                r_dout <= w_s;
            end
            r_rise <= w_qualify & w_s;
            r_fall <= w_qualify & ~w_s;
        end
    end

    assign dout       = r_dout;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module  : tb_debounce_sync
// Brief   : Scoreboard bench for debounce_sync (DEBOUNCE_CYCLES=4 and =1 builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_debounce_sync;

    typedef struct {
        logic rise;
        int   cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic din0, din1;
    logic dout0, rise0, fall0, busy0;
    logic dout1, rise1, fall1, busy1;

    int   cyc;
    int   checks;
    int   failures;
    logic busy1_seen;
    exp_t q0[$];
    exp_t q1[$];

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_async  (din0),
        .dout       (dout0),
        .rise_pulse (rise0),
        .fall_pulse (fall0),
        .busy       (busy0)
    );

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_async  (din1),
        .dout       (dout1),
        .rise_pulse (rise1),
        .fall_pulse (fall1),
        .busy       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every pulse seen must be the next one queued, with matching direction and cycle.
    task automatic see_pulse(input int inst, input logic r, input logic f);
        exp_t e;
        if (!(r || f)) return;
        checks++;
        if (r && f) begin
            failures++;
            $display("FAIL both_pulses inst%0d: rise=1 fall=1 expected one (cycle %0d)", inst, cyc);
            return;
        end
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            failures++;
            $display("FAIL unexpected_pulse inst%0d: rise=%0d fall=%0d expected none (cycle %0d)",
                     inst, r, f, cyc);
            return;
        end
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        if (e.rise != r || e.cyc != cyc) begin
            failures++;
            $display("FAIL pulse inst%0d: got rise=%0d at cycle %0d expected rise=%0d at cycle %0d",
                     inst, r, cyc, e.rise, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        see_pulse(0, rise0, fall0);
        see_pulse(1, rise1, fall1);
        if (busy1) busy1_seen = 1'b1;
    end

    initial begin
        int n;
        checks     = 0;
        failures   = 0;
        busy1_seen = 1'b0;
        rst_n      = 1'b1;
        din0       = 1'b1;
        din1       = 1'b0;

        // Reset with no clock edge yet, input already high.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_dout", dout0, 0);
        chk("reset_rise", rise0, 0);
        chk("reset_fall", fall0, 0);
        chk("reset_busy", busy0, 0);

        // Release with din held high: busy after edges 3-5, rise at edge 6.
        @(negedge clk);
        rst_n = 1'b1;
        n = cyc;
        q0.push_back('{rise: 1'b1, cyc: n + 6});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("rel_busy_e%0d", k), busy0, (k >= 3 && k <= 5) ? 1 : 0);
            chk($sformatf("rel_dout_e%0d", k), dout0, (k >= 6) ? 1 : 0);
        end

        // Falling edge held.
        din0 = 1'b0;
        n = cyc;
        q0.push_back('{rise: 1'b0, cyc: n + 6});
        repeat (5) @(negedge clk);
        chk("fall_dout_e5", dout0, 1);
        @(negedge clk);
        chk("fall_dout_e6", dout0, 0);
        repeat (3) @(negedge clk);

        // Glitch of exactly 3 edges must be rejected.
        din0 = 1'b1;
        repeat (3) @(negedge clk);
        din0 = 1'b0;
        chk("glitch_busy_on", busy0, 1);
        repeat (3) @(negedge clk);
        chk("glitch_busy_off", busy0, 0);
        repeat (4) @(negedge clk);
        chk("glitch_dout", dout0, 0);

        // Bounce: 2-edge segments never qualify; final hold yields one rise.
        for (int i = 0; i < 10; i++) begin
            din0 = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (2) @(negedge clk);
            chk($sformatf("bounce_dout_%0d", i), dout0, 0);
        end
        din0 = 1'b1;
        n = cyc;
        q0.push_back('{rise: 1'b1, cyc: n + 6});
        repeat (8) @(negedge clk);
        chk("bounce_final_dout", dout0, 1);

        // Async reset mid-count clears everything without a clock edge.
        din0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("midcnt_busy", busy0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy0, 0);
        chk("arst_dout", dout0, 0);
        din0 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n = cyc;
        q0.push_back('{rise: 1'b1, cyc: n + 6});
        repeat (5) @(negedge clk);
        chk("arst_relat_e5", dout0, 0);
        @(negedge clk);
        chk("arst_relat_e6", dout0, 1);
        repeat (3) @(negedge clk);

        // DEBOUNCE_CYCLES=1 build: dout follows s one edge later.
        din1 = 1'b1;
        n = cyc;
        q1.push_back('{rise: 1'b1, cyc: n + 3});
        repeat (2) @(negedge clk);
        chk("dc1_dout_e2", dout1, 0);
        @(negedge clk);
        chk("dc1_dout_e3", dout1, 1);
        din1 = 1'b0;
        n = cyc;
        q1.push_back('{rise: 1'b0, cyc: n + 3});
        repeat (3) @(negedge clk);
        chk("dc1_fall_dout", dout1, 0);

        repeat (10) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("dc1_busy_never", int'(busy1_seen), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
